turn_signal_ctrl: RTL

- Parametrised successor to the car winker state machine.
- Drives left and right turn lamps with a programmable blink period, supports hazard mode, and auto-cancels after N blinks (comfort blink).
- Fully synchronous single-clock design. The lamps are registered, not gated from clk.
- Sits between the steering-column switch decoder (1-cycle request pulses) and the lamp driver stage.

---
 rtl/turn_signal_ctrl_if.sv | 35 +++
 rtl/turn_signal_ctrl.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/turn_signal_ctrl_if.sv
// Switch-decoder requests in, lamp/status outputs back; slave side is the controller.
// TURN_SIGNAL_HYPERFLASH_EN adds the lamp_fault input.
interface turn_signal_ctrl_if #(
    parameter int CNT_W = 8
);
`ifdef TURN_SIGNAL_HYPERFLASH_EN
    logic [1:0]       lamp_fault;
`endif
    logic             left_req;
    logic             right_req;
    logic             hazard_req;
    logic             off_req;
    logic [2:0]       o_state;
    logic             o_left_led;
    logic             o_right_led;
    logic             o_busy;
    logic             o_done;
    logic [CNT_W-1:0] o_blink_cnt;

    modport master (
`ifdef TURN_SIGNAL_HYPERFLASH_EN
        output lamp_fault,
`endif
        output left_req, right_req, hazard_req, off_req,
        input  o_state, o_left_led, o_right_led, o_busy, o_done, o_blink_cnt
    );

    modport slave (
`ifdef TURN_SIGNAL_HYPERFLASH_EN
        input  lamp_fault,
`endif
        input  left_req, right_req, hazard_req, off_req,
        output o_state, o_left_led, o_right_led, o_busy, o_done, o_blink_cnt
    );
endinterface

// File: rtl/turn_signal_ctrl.sv
// Turn-signal / hazard controller with programmable blink period and comfort auto-cancel.
// Optional TURN_SIGNAL_HYPERFLASH_EN: double-rate flash when an active lamp reports open.
module turn_signal_ctrl #(
    parameter int BLINK_HALF_CYC  = 4,
    parameter int AUTO_OFF_BLINKS = 3,
    parameter int CNT_W           = 8
) (
    input logic              clk,
    input logic              reset_n,
    turn_signal_ctrl_if.slave bus
);
    localparam logic [CNT_W-1:0] HALF      = CNT_W'(BLINK_HALF_CYC);
    localparam logic [CNT_W-1:0] HALF_FAST = CNT_W'((BLINK_HALF_CYC + 1) / 2);
    localparam logic [CNT_W-1:0] AUTO      = CNT_W'(AUTO_OFF_BLINKS);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEFT   = 3'd1,
        S_RIGHT  = 3'd2,
        S_HAZARD = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    state_t           r_state, w_nxt_state, w_enter_state;
    logic [CNT_W-1:0] r_phase, w_nxt_phase;
    logic [CNT_W-1:0] r_blink_cnt, w_nxt_cnt, w_cnt_inc;
    logic [CNT_W-1:0] w_half;
    logic             r_lamp_on, w_nxt_on;
    logic             r_left_led, r_right_led;
    logic             w_enter, w_adv, w_half_end;
    logic             w_l, w_r, w_h, w_o;

    assign w_l = bus.left_req;
    assign w_r = bus.right_req;
    assign w_h = bus.hazard_req;
    assign w_o = bus.off_req;

`ifdef TURN_SIGNAL_HYPERFLASH_EN
    // Rate is latched at entry and at each half-period boundary so a fault
    // change never truncates or stretches the half-period in progress.
    logic [CNT_W-1:0] r_half;
    logic             w_fault, w_load_half;
    assign w_fault = (w_nxt_state == S_LEFT   && bus.lamp_fault[0]) ||
                     (w_nxt_state == S_RIGHT  && bus.lamp_fault[1]) ||
                     (w_nxt_state == S_HAZARD && (|bus.lamp_fault));
    assign w_load_half = w_enter || (w_adv && w_half_end);
    assign w_half = r_half;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)         r_half <= HALF;
        else if (w_load_half) r_half <= w_fault ? HALF_FAST : HALF;
    end
`else
    assign w_half = HALF;
`endif

    assign w_half_end = (r_phase >= w_half - 1'b1);
    assign w_cnt_inc  = (r_blink_cnt == CNT_MAX) ? r_blink_cnt : r_blink_cnt + 1'b1;

    always_comb begin
        w_nxt_state   = r_state;
        w_nxt_phase   = r_phase;
        w_nxt_on      = r_lamp_on;
        w_nxt_cnt     = r_blink_cnt;
        w_enter       = 1'b0;
        w_enter_state = r_state;
        w_adv         = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_nxt_cnt = '0;
                if (w_h) begin
                    w_enter = 1'b1; w_enter_state = S_HAZARD;
                end else if (w_l ^ w_r) begin
                    w_enter = 1'b1; w_enter_state = w_l ? S_LEFT : S_RIGHT;
                end
            end
            S_LEFT, S_RIGHT: begin
                if (w_o) begin
                    w_nxt_state = S_FINISH;
                end else if (w_h) begin
                    w_enter = 1'b1; w_enter_state = S_HAZARD;
                end else if (r_state == S_LEFT && w_r && !w_l) begin
                    w_enter = 1'b1; w_enter_state = S_RIGHT;
                end else if (r_state == S_RIGHT && w_l && !w_r) begin
                    w_enter = 1'b1; w_enter_state = S_LEFT;
                end else begin
                    w_adv = 1'b1;
                end
            end
            S_HAZARD: begin
                if (w_o || w_h) w_nxt_state = S_FINISH;
                else            w_adv = 1'b1;
            end
            S_FINISH: begin
                w_nxt_state = S_IDLE;
                w_nxt_cnt   = '0;
            end
            default: w_nxt_state = S_IDLE;
        endcase

        // A blink completes at the end of its low half; that edge may auto-cancel.
        if (w_adv) begin
            if (w_half_end) begin
                w_nxt_phase = '0;
                if (r_lamp_on) begin
                    w_nxt_on = 1'b0;
                end else begin
                    w_nxt_cnt = w_cnt_inc;
                    if (AUTO != '0 && r_state != S_HAZARD && w_cnt_inc == AUTO)
                        w_nxt_state = S_FINISH;
                    else
                        w_nxt_on = 1'b1;
                end
            end else begin
                w_nxt_phase = r_phase + 1'b1;
            end
        end

        if (w_enter) begin
            w_nxt_state = w_enter_state;
            w_nxt_phase = '0;
            w_nxt_on    = 1'b1;
            w_nxt_cnt   = '0;
        end

        if (w_nxt_state == S_FINISH || w_nxt_state == S_IDLE) begin
            w_nxt_phase = '0;
            w_nxt_on    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_phase     <= '0;
            r_lamp_on   <= 1'b0;
            r_blink_cnt <= '0;
            r_left_led  <= 1'b0;
            r_right_led <= 1'b0;
        end else begin
            r_state     <= w_nxt_state;
            r_phase     <= w_nxt_phase;
            r_lamp_on   <= w_nxt_on;
            r_blink_cnt <= w_nxt_cnt;
            r_left_led  <= w_nxt_on && (w_nxt_state == S_LEFT  || w_nxt_state == S_HAZARD);
            r_right_led <= w_nxt_on && (w_nxt_state == S_RIGHT || w_nxt_state == S_HAZARD);
        end
    end

    assign bus.o_state     = r_state;
    assign bus.o_left_led  = r_left_led;
    assign bus.o_right_led = r_right_led;
    assign bus.o_busy      = (r_state == S_LEFT) || (r_state == S_RIGHT) || (r_state == S_HAZARD);
    assign bus.o_done      = (r_state == S_FINISH);
    assign bus.o_blink_cnt = r_blink_cnt;
endmodule
